ram_rr_arbiter: RTL and testbench

RAM_RR_ARBITER -- requirements
Module: ram_rr_arbiter

---
 rtl/ram_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_ram_rr_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port asynchronous RAM among NREQ requesters.
// One access at a time: a write takes two cycles, a read takes three.
module ram_rr_arbiter #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 8,
    parameter int NREQ   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*AWIDTH-1:0]   req_addr,
    input  logic [NREQ*DWIDTH-1:0]   req_wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rvalid,
    output logic [DWIDTH-1:0]        rdata,
    output logic                     busy,
    output logic                     ram_cs,
    output logic                     ram_oe,
    output logic                     ram_we,
    output logic [AWIDTH-1:0]        ram_addr,
    output logic [DWIDTH-1:0]        ram_wdata,
    output logic                     ram_wdata_oe,
    input  logic [DWIDTH-1:0]        ram_rdata,
    output logic [1:0]               dbg_state
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RDATA = 2'd3
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win_q;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   ptr_next;
    logic            win_found;
    logic [PW:0]     cand_sum;
    logic [PW-1:0]   cand;

    // Rotating priority search starting at ptr. Scanning from the farthest
    // offset down lets the nearest requesting index overwrite the result last.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand_sum  = '0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand_sum = {1'b0, ptr} + (PW+1)'(k);
            if (cand_sum >= (PW+1)'(NREQ)) begin
                cand_sum = cand_sum - (PW+1)'(NREQ);
            end
            cand = cand_sum[PW-1:0];
            if (req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    assign ptr_next = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

    // Handshake: a requester holds req and its payload until it sees gnt high
    // in a cycle; that cycle is the accept. Read completion is the one-cycle
    // rvalid strobe with rdata valid alongside and held afterwards.
    always_comb begin
        gnt = '0;
        if (rst_n && state == S_IDLE && win_found) begin
            gnt[win_idx] = 1'b1;
        end
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            ptr          <= '0;
            win_q        <= '0;
            rvalid       <= '0;
            rdata        <= '0;
            ram_cs       <= 1'b0;
            ram_oe       <= 1'b0;
            ram_we       <= 1'b0;
            ram_wdata_oe <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
        end else begin
            rvalid <= '0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        ram_addr  <= req_addr[int'(win_idx)*AWIDTH +: AWIDTH];
                        ram_wdata <= req_wdata[int'(win_idx)*DWIDTH +: DWIDTH];
                        win_q     <= win_idx;
                        ptr       <= ptr_next;
                        ram_cs    <= 1'b1;
                        if (req_we[win_idx]) begin
                            state        <= S_WRITE;
                            ram_we       <= 1'b1;
                            ram_wdata_oe <= 1'b1;
                        end else begin
                            state  <= S_READ;
                            ram_oe <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    state        <= S_IDLE;
                    ram_cs       <= 1'b0;
                    ram_we       <= 1'b0;
                    ram_wdata_oe <= 1'b0;
                end
                S_READ: begin
                    // Second read cycle gives the asynchronous RAM a full cycle of access time.
                    state <= S_RDATA;
                end
                S_RDATA: begin
                    state         <= S_IDLE;
                    rdata         <= ram_rdata;
                    rvalid[win_q] <= 1'b1;
                    ram_cs        <= 1'b0;
                    ram_oe        <= 1'b0;
                end
                default: begin
                    state        <= S_IDLE;
                    ram_cs       <= 1'b0;
                    ram_oe       <= 1'b0;
                    ram_we       <= 1'b0;
                    ram_wdata_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter with a behavioural RAM attached (NREQ=4, 8-bit data/address).
module tb_ram_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [7:0]  rdata;
    logic        busy;
    logic        ram_cs;
    logic        ram_oe;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_wdata_oe;
    logic [7:0]  ram_rdata;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    ram_rr_arbiter #(.DWIDTH(8), .AWIDTH(8), .NREQ(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
        .rvalid(rvalid), .rdata(rdata), .busy(busy), .ram_cs(ram_cs),
        .ram_oe(ram_oe), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_wdata_oe(ram_wdata_oe),
        .ram_rdata(ram_rdata), .dbg_state(dbg_state)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sim time exceeded, n_err=%0d", n_err);
        $fatal(1);
    end

    // behavioural RAM with a bench preload port and an access tracker for address 0x77
    logic [7:0] mem [0:255];
    logic       pl_en = 1'b0;
    logic [7:0] pl_addr = 8'h00;
    logic [7:0] pl_data = 8'h00;
    int         acc77 = 0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_cs && ram_addr == 8'h77) acc77 <= acc77 + 1;
    end
    assign ram_rdata = mem[ram_addr];

    // driver tasks
    task automatic set_req(input int i, input logic we, input logic [7:0] a, input logic [7:0] d);
        req[i] = 1'b1;
        req_we[i] = we;
        req_addr[i*8 +: 8] = a;
        req_wdata[i*8 +: 8] = d;
    endtask

    task automatic clr_req(input int i);
        req[i] = 1'b0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 4'hF; req_we = 4'h0;
        @(negedge clk); @(negedge clk); #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (rvalid !== 4'b0000) begin n_err++; $display("FAIL rst_rvalid: got %b want 0000", rvalid); end
        n_cmp++; if (rdata !== 8'h00) begin n_err++; $display("FAIL rst_rdata: got %h want 00", rdata); end
        n_cmp++; if ({ram_cs, ram_oe, ram_we, ram_wdata_oe} !== 4'b0000) begin n_err++;
            $display("FAIL rst_ctrl: got %b want 0000", {ram_cs, ram_oe, ram_we, ram_wdata_oe}); end
        n_cmp++; if ({ram_addr, ram_wdata} !== 16'h0000) begin n_err++;
            $display("FAIL rst_addr_wdata: got %h want 0000", {ram_addr, ram_wdata}); end
        n_cmp++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
        req = '0; rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_write_read();
        @(negedge clk); set_req(1, 1'b1, 8'h10, 8'hA5); #1;
        n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL wr_gnt: got %b want 0010", gnt); end
        @(negedge clk); clr_req(1); #1;
        n_cmp++; if ({ram_cs, ram_oe, ram_we, ram_wdata_oe} !== 4'b1011) begin n_err++;
            $display("FAIL wr_ctrl: got %b want 1011", {ram_cs, ram_oe, ram_we, ram_wdata_oe}); end
        n_cmp++; if (ram_addr !== 8'h10 || ram_wdata !== 8'hA5) begin n_err++;
            $display("FAIL wr_bus: got addr %h data %h want 10 a5", ram_addr, ram_wdata); end
        n_cmp++; if (busy !== 1'b1 || dbg_state !== 2'd1) begin n_err++;
            $display("FAIL wr_busy: got busy %b state %0d want 1 1", busy, dbg_state); end
        @(negedge clk); #1;
        n_cmp++; if (mem[8'h10] !== 8'hA5) begin n_err++; $display("FAIL wr_mem: got %h want a5", mem[8'h10]); end
        n_cmp++; if (busy !== 1'b0 || {ram_cs, ram_oe, ram_we, ram_wdata_oe} !== 4'b0000) begin n_err++;
            $display("FAIL wr_idle: got busy %b ctrl %b want 0 0000", busy, {ram_cs, ram_oe, ram_we, ram_wdata_oe}); end
        set_req(1, 1'b0, 8'h10, 8'h00); #1;
        n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL rd_gnt: got %b want 0010", gnt); end
        @(negedge clk); clr_req(1); #1;
        n_cmp++; if ({ram_cs, ram_oe, ram_we, ram_wdata_oe} !== 4'b1100 || dbg_state !== 2'd2) begin n_err++;
            $display("FAIL rd_ctrl: got %b state %0d want 1100 2", {ram_cs, ram_oe, ram_we, ram_wdata_oe}, dbg_state); end
        @(negedge clk); #1;
        n_cmp++; if ({ram_cs, ram_oe, ram_we, ram_wdata_oe} !== 4'b1100 || dbg_state !== 2'd3 || rvalid !== 4'b0000) begin
            n_err++; $display("FAIL rdata_ctrl: got %b state %0d rvalid %b want 1100 3 0000",
                {ram_cs, ram_oe, ram_we, ram_wdata_oe}, dbg_state, rvalid); end
        @(negedge clk); #1;
        n_cmp++; if (rvalid !== 4'b0010 || rdata !== 8'hA5) begin n_err++;
            $display("FAIL rd_rvalid: got %b %h want 0010 a5", rvalid, rdata); end
        @(negedge clk); #1;
        n_cmp++; if (rvalid !== 4'b0000 || rdata !== 8'hA5) begin n_err++;
            $display("FAIL rd_hold: got %b %h want 0000 a5", rvalid, rdata); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [3:0] exp_rv;
        logic [7:0] exp_d;
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'h20 + 8'(i), 8'h00);
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_g = (c % 3 == 0) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
            n_cmp++; if (gnt !== exp_g) begin n_err++; $display("FAIL rr_gnt c%0d: got %b want %b", c, gnt, exp_g); end
            if (c % 3 == 0 && c > 0) begin
                exp_rv = 4'b0001 << ((c / 3 - 1) % 4);
                exp_d = 8'h50 + 8'((c / 3 - 1) % 4);
                n_cmp++; if (rvalid !== exp_rv || rdata !== exp_d) begin n_err++;
                    $display("FAIL rr_rvalid c%0d: got %b %h want %b %h", c, rvalid, rdata, exp_rv, exp_d); end
            end
        end
        @(negedge clk); req = '0;
        @(negedge clk); @(negedge clk); #1;
        n_cmp++; if (rvalid !== 4'b0001 || rdata !== 8'h50) begin n_err++;
            $display("FAIL rr_last: got %b %h want 0001 50", rvalid, rdata); end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_g;
        @(negedge clk); set_req(2, 1'b0, 8'h22, 8'h00); #1;
        n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL wrap_setup: got %b want 0100", gnt); end
        @(negedge clk); clr_req(2);
        @(negedge clk); @(negedge clk);
        set_req(0, 1'b0, 8'h20, 8'h00); set_req(1, 1'b0, 8'h21, 8'h00);
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) clr_req(0);
            if (c == 4) clr_req(1);
            #1;
            exp_g = (c == 0) ? 4'b0001 : (c == 3) ? 4'b0010 : 4'b0000;
            n_cmp++; if (gnt !== exp_g) begin n_err++; $display("FAIL wrap_gnt c%0d: got %b want %b", c, gnt, exp_g); end
        end
        @(negedge clk); #1;
        n_cmp++; if (rvalid !== 4'b0010 || rdata !== 8'h51) begin n_err++;
            $display("FAIL wrap_rvalid: got %b %h want 0010 51", rvalid, rdata); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_req(0, 1'b1, 8'h00, 8'h3C); set_req(2, 1'b0, 8'h00, 8'h00); #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL b2b_gnt_w: got %b want 0001", gnt); end
        @(negedge clk); clr_req(0); #1;
        n_cmp++; if ({ram_cs, ram_oe, ram_we, ram_wdata_oe} !== 4'b1011 || ram_addr !== 8'h00 || ram_wdata !== 8'h3C
            || gnt !== 4'b0000) begin n_err++;
            $display("FAIL b2b_write: got ctrl %b addr %h data %h gnt %b want 1011 00 3c 0000",
                {ram_cs, ram_oe, ram_we, ram_wdata_oe}, ram_addr, ram_wdata, gnt); end
        @(negedge clk); #1;
        n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL b2b_gnt_r: got %b want 0100", gnt); end
        @(negedge clk); clr_req(2); #1;
        n_cmp++; if ({ram_cs, ram_oe, ram_we, ram_wdata_oe} !== 4'b1100) begin n_err++;
            $display("FAIL b2b_read: got %b want 1100", {ram_cs, ram_oe, ram_we, ram_wdata_oe}); end
        @(negedge clk); #1;
        n_cmp++; if (rvalid !== 4'b0000) begin n_err++; $display("FAIL b2b_early: got %b want 0000", rvalid); end
        @(negedge clk); #1;
        n_cmp++; if (rvalid !== 4'b0100 || rdata !== 8'h3C) begin n_err++;
            $display("FAIL b2b_rvalid: got %b %h want 0100 3c", rvalid, rdata); end
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk); set_req(1, 1'b0, 8'h10, 8'h00); #1;
        n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL mid_gnt: got %b want 0010", gnt); end
        @(negedge clk); clr_req(1);
        @(negedge clk); #1;
        n_cmp++; if (dbg_state !== 2'd3) begin n_err++; $display("FAIL mid_state: got %0d want 3", dbg_state); end
        rst_n = 1'b0;
        set_req(1, 1'b0, 8'h10, 8'h00); set_req(2, 1'b0, 8'h22, 8'h00);
        @(negedge clk); #1;
        n_cmp++; if (busy !== 1'b0 || rvalid !== 4'b0000 || rdata !== 8'h00 || ram_cs !== 1'b0) begin n_err++;
            $display("FAIL mid_abort: got busy %b rvalid %b rdata %h cs %b want 0 0000 00 0", busy, rvalid, rdata, ram_cs); end
        n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL mid_rst_gnt: got %b want 0000", gnt); end
        rst_n = 1'b1; #1;
        n_cmp++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL mid_post_gnt: got %b want 0010", gnt); end
        @(negedge clk); req = '0; #1;
        n_cmp++; if (rvalid !== 4'b0000) begin n_err++; $display("FAIL mid_no_rvalid: got %b want 0000", rvalid); end
        @(negedge clk); @(negedge clk); #1;
        n_cmp++; if (rvalid !== 4'b0010 || rdata !== 8'hA5) begin n_err++;
            $display("FAIL mid_rvalid: got %b %h want 0010 a5", rvalid, rdata); end
    endtask

    task automatic test_withdrawn();
        @(negedge clk); set_req(0, 1'b0, 8'h10, 8'h00); #1;
        n_cmp++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL wd_gnt0: got %b want 0001", gnt); end
        @(negedge clk); clr_req(0); set_req(3, 1'b1, 8'h77, 8'hEE); #1;
        n_cmp++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL wd_busy1: got %b want 0000", gnt); end
        @(negedge clk); #1;
        n_cmp++; if (gnt !== 4'b0000 || ram_addr !== 8'h10) begin n_err++;
            $display("FAIL wd_busy2: got gnt %b addr %h want 0000 10", gnt, ram_addr); end
        clr_req(3);
        @(negedge clk); #1;
        n_cmp++; if (gnt !== 4'b0000 || rvalid !== 4'b0001 || busy !== 1'b0) begin n_err++;
            $display("FAIL wd_idle: got gnt %b rvalid %b busy %b want 0000 0001 0", gnt, rvalid, busy); end
        @(negedge clk); @(negedge clk); #1;
        n_cmp++; if (acc77 !== 0 || busy !== 1'b0) begin n_err++;
            $display("FAIL wd_no_access: got acc77 %0d busy %b want 0 0", acc77, busy); end
    endtask

    initial begin
        rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        test_reset();
        test_single_write_read();
        for (int i = 0; i < 4; i++) preload(8'h20 + 8'(i), 8'h50 + 8'(i));
        test_round_robin();
        test_wrap();
        test_back_to_back();
        test_reset_mid_read();
        test_withdrawn();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
